// File: rtl/dds_param_scheduler.sv
// dds_param_scheduler
//   Timed parameter scheduler feeding the DDS phase MAC. Owns the free-running
//   timestamp (MAC D) and a small command FIFO. Each command is applied when the
//   timestamp reaches its scheduled time, so the new freq/phase/time-offset
//   operands appear in the same cycle as the matching timestamp.
//
// Optional build macro: DDS_SCHED_LATE_DROP_EN
//   defined   - a late head is popped and discarded (only late_error is set)
//   undefined - a late head is applied at the next edge and late_error is set
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   cmd_valid/ready   command handshake (ready = !fifo_full)
//   cmd_time          scheduled apply time
//   cmd_freq          frequency word
//   cmd_phase         14-bit phase offset
//   cmd_sync          reload time offset with cmd_time when applied
//   flush             discard all queued commands (beats push and apply)
//   timestamp_out     free-running counter        (MAC D)
//   time_offset_out   phase reference time        (MAC A)
//   freq_out          active frequency            (MAC B)
//   phase_out         active phase                (MAC C)
//   param_update      one-cycle pulse aligned with new operands
//   fifo_empty/full   FIFO occupancy flags
//   late_error        sticky: a command's time had already passed
module dds_param_scheduler #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TS_WIDTH   = 48
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [TS_WIDTH-1:0] cmd_time,
    input  logic [TS_WIDTH-1:0] cmd_freq,
    input  logic [13:0]         cmd_phase,
    input  logic                cmd_sync,
    input  logic                flush,
    output logic [TS_WIDTH-1:0] timestamp_out,
    output logic [TS_WIDTH-1:0] time_offset_out,
    output logic [TS_WIDTH-1:0] freq_out,
    output logic [13:0]         phase_out,
    output logic                param_update,
    output logic                fifo_empty,
    output logic                fifo_full,
    output logic                late_error
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        HEAD_EMPTY,
        HEAD_WAIT,
        HEAD_APPLY
    } head_state_e;

    logic [TS_WIDTH-1:0] mem_time_q  [FIFO_DEPTH];
    logic [TS_WIDTH-1:0] mem_time_d  [FIFO_DEPTH];
    logic [TS_WIDTH-1:0] mem_freq_q  [FIFO_DEPTH];
    logic [TS_WIDTH-1:0] mem_freq_d  [FIFO_DEPTH];
    logic [13:0]         mem_phase_q [FIFO_DEPTH];
    logic [13:0]         mem_phase_d [FIFO_DEPTH];
    logic                mem_sync_q  [FIFO_DEPTH];
    logic                mem_sync_d  [FIFO_DEPTH];

    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]       count_q, count_d;

    logic [TS_WIDTH-1:0] ts_q, ts_d;
    logic [TS_WIDTH-1:0] time_offset_q, time_offset_d;
    logic [TS_WIDTH-1:0] freq_q, freq_d;
    logic [13:0]         phase_q, phase_d;
    logic                param_update_q, param_update_d;
    logic                late_error_q, late_error_d;

    logic                empty;
    logic                full;
    logic [TS_WIDTH-1:0] head_time;
    logic [TS_WIDTH-1:0] head_diff;
    logic                head_late;
    logic                pop;
    logic                push;
    logic                load;
    head_state_e         head_state;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(FIFO_DEPTH));
    assign head_time = mem_time_q[rd_ptr_q];
    // Cycles until the head must be visible; the edge that makes it visible
    // is the one after the current cycle, hence ts + 1.
    assign head_diff = head_time - (ts_q + TS_WIDTH'(1));

    // Head classification is purely combinational so an entry pushed at edge N
    // can already be applied at edge N+1.
    always_comb begin
        head_state = HEAD_EMPTY;
        head_late  = 1'b0;
        if (!empty) begin
            if (head_diff[TS_WIDTH-1]) begin
                head_state = HEAD_APPLY;
                head_late  = 1'b1;
            end else if (head_diff == '0) begin
                head_state = HEAD_APPLY;
            end else begin
                head_state = HEAD_WAIT;
            end
        end
    end

    always_comb begin
        mem_time_d     = mem_time_q;
        mem_freq_d     = mem_freq_q;
        mem_phase_d    = mem_phase_q;
        mem_sync_d     = mem_sync_q;
        rd_ptr_d       = rd_ptr_q;
        wr_ptr_d       = wr_ptr_q;
        count_d        = count_q;
        ts_d           = ts_q;
        time_offset_d  = time_offset_q;
        freq_d         = freq_q;
        phase_d        = phase_q;
        param_update_d = 1'b0;
        late_error_d   = late_error_q;
        pop            = 1'b0;
        push           = 1'b0;
        load           = 1'b0;

        if (flush) begin
            // Counter and active operands hold; queue is emptied.
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            ts_d = ts_q + TS_WIDTH'(1);
            pop  = (head_state == HEAD_APPLY);
            // Full is judged before this cycle's pop.
            push = cmd_valid && !full;
`ifdef DDS_SCHED_LATE_DROP_EN
            load = pop && !head_late;
`else
            load = pop;
`endif
            param_update_d = load;
            if (load) begin
                freq_d  = mem_freq_q[rd_ptr_q];
                phase_d = mem_phase_q[rd_ptr_q];
                if (mem_sync_q[rd_ptr_q]) begin
                    time_offset_d = head_time;
                end
            end
            if (head_late) begin
                late_error_d = 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push) begin
                mem_time_d[wr_ptr_q]  = cmd_time;
                mem_freq_d[wr_ptr_q]  = cmd_freq;
                mem_phase_d[wr_ptr_q] = cmd_phase;
                mem_sync_d[wr_ptr_q]  = cmd_sync;
                wr_ptr_d              = wr_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            count_q        <= '0;
            ts_q           <= '0;
            time_offset_q  <= '0;
            freq_q         <= '0;
            phase_q        <= '0;
            param_update_q <= 1'b0;
            late_error_q   <= 1'b0;
        end else begin
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            count_q        <= count_d;
            ts_q           <= ts_d;
            time_offset_q  <= time_offset_d;
            freq_q         <= freq_d;
            phase_q        <= phase_d;
            param_update_q <= param_update_d;
            late_error_q   <= late_error_d;
        end
    end

    // Storage needs no reset: entries are only read while count_q says valid.
    always_ff @(posedge clk) begin
        mem_time_q  <= mem_time_d;
        mem_freq_q  <= mem_freq_d;
        mem_phase_q <= mem_phase_d;
        mem_sync_q  <= mem_sync_d;
    end

    assign cmd_ready       = !full;
    assign fifo_empty      = empty;
    assign fifo_full       = full;
    assign timestamp_out   = ts_q;
    assign time_offset_out = time_offset_q;
    assign freq_out        = freq_q;
    assign phase_out       = phase_q;
    assign param_update    = param_update_q;
    assign late_error      = late_error_q;

endmodule

// File: tb/tb_dds_param_scheduler.sv
module tb_dds_param_scheduler;

    localparam int W  = 48;
    localparam int D  = 4;
    localparam int WW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [W-1:0]  cmd_time = '0;
    logic [W-1:0]  cmd_freq = '0;
    logic [13:0]   cmd_phase = '0;
    logic          cmd_sync = 1'b0;
    logic          flush = 1'b0;
    logic [W-1:0]  timestamp_out, time_offset_out, freq_out;
    logic [13:0]   phase_out;
    logic          param_update, fifo_empty, fifo_full, late_error;

    dds_param_scheduler #(.FIFO_DEPTH(D), .TS_WIDTH(W)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_time(cmd_time), .cmd_freq(cmd_freq), .cmd_phase(cmd_phase),
        .cmd_sync(cmd_sync), .flush(flush), .timestamp_out(timestamp_out),
        .time_offset_out(time_offset_out), .freq_out(freq_out), .phase_out(phase_out),
        .param_update(param_update), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
        .late_error(late_error)
    );

    // Narrow instance so counter wrap is reachable in a short run.
    logic          w_reset = 1'b1;
    logic          w_valid = 1'b0;
    logic          w_ready;
    logic [WW-1:0] w_time = '0;
    logic [WW-1:0] w_freq = '0;
    logic [13:0]   w_phase = '0;
    logic          w_sync = 1'b0;
    logic          w_flush = 1'b0;
    logic [WW-1:0] w_ts, w_off, w_fout;
    logic [13:0]   w_pout;
    logic          w_upd, w_empty, w_full, w_late;

    dds_param_scheduler #(.FIFO_DEPTH(2), .TS_WIDTH(WW)) dut_w (
        .clk(clk), .reset(w_reset), .cmd_valid(w_valid), .cmd_ready(w_ready),
        .cmd_time(w_time), .cmd_freq(w_freq), .cmd_phase(w_phase),
        .cmd_sync(w_sync), .flush(w_flush), .timestamp_out(w_ts),
        .time_offset_out(w_off), .freq_out(w_fout), .phase_out(w_pout),
        .param_update(w_upd), .fifo_empty(w_empty), .fifo_full(w_full),
        .late_error(w_late)
    );

    int checks = 0;
    int fails  = 0;

    // Behavioural model of the 48-bit instance: a queue of pending commands
    // plus the visible operand registers.
    typedef struct packed {
        logic [W-1:0] t;
        logic [W-1:0] f;
        logic [13:0]  p;
        logic         s;
    } cmd_t;

    cmd_t         mq[$];
    logic [W-1:0] m_ts = '0, m_off = '0, m_freq = '0;
    logic [13:0]  m_phase = '0;
    logic         m_upd = 1'b0, m_late = 1'b0;

    // Advance the model by one clock using the inputs currently driven, then
    // let the DUT take the same edge and settle.
    task automatic tick();
        logic [W-1:0]        dd;
        logic signed [W-1:0] ds;
        bit                  was_full;
        cmd_t                c;
        if (reset) begin
            mq.delete();
            m_ts = '0; m_off = '0; m_freq = '0; m_phase = '0;
            m_upd = 1'b0; m_late = 1'b0;
        end else if (flush) begin
            mq.delete();
            m_upd = 1'b0;
        end else begin
            was_full = (mq.size() == D);
            m_upd = 1'b0;
            if (mq.size() > 0) begin
                dd = mq[0].t - (m_ts + 1);
                ds = dd;
                if (ds <= 0) begin
                    if (ds < 0) m_late = 1'b1;
`ifdef DDS_SCHED_LATE_DROP_EN
                    if (ds == 0) begin
`else
                    begin
`endif
                        m_freq  = mq[0].f;
                        m_phase = mq[0].p;
                        if (mq[0].s) m_off = mq[0].t;
                        m_upd   = 1'b1;
                    end
                    void'(mq.pop_front());
                end
            end
            if (cmd_valid && !was_full) begin
                c.t = cmd_time; c.f = cmd_freq; c.p = cmd_phase; c.s = cmd_sync;
                mq.push_back(c);
            end
            m_ts = m_ts + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ts(input logic [W-1:0] target);
        int unsigned n = 0;
        while (m_ts != target && n < 5000) begin
            tick();
            n++;
        end
        if (m_ts != target) begin
            checks++; fails++;
            $display("FAIL wait_ts: timestamp %0d never reached target %0d", m_ts, target);
        end
    endtask

    task automatic push_cmd(input logic [W-1:0] t, input logic [W-1:0] f,
                            input logic [13:0] p, input logic s);
        cmd_valid = 1'b1; cmd_time = t; cmd_freq = f; cmd_phase = p; cmd_sync = s;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        checks++;
        if ({timestamp_out, time_offset_out, freq_out, phase_out, param_update, late_error} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: ts=%0d off=%0d freq=%0h ph=%0h upd=%b late=%b, all required 0",
                     timestamp_out, time_offset_out, freq_out, phase_out, param_update, late_error);
        end
        checks++;
        if ({fifo_empty, fifo_full, cmd_ready} !== 3'b101) begin
            fails++;
            $display("FAIL reset_flags: empty/full/ready=%b%b%b required 101", fifo_empty, fifo_full, cmd_ready);
        end
    endtask

    task automatic test_timed_apply();
        wait_ts(10);
        push_cmd(100, 48'h1000, 14'h155, 1'b1);
        wait_ts(99);
        checks++;
        if (param_update !== 1'b0 || freq_out !== '0) begin
            fails++;
            $display("FAIL timed_early: upd=%b freq=%0h at ts 99, required 0/0", param_update, freq_out);
        end
        tick();
        checks++;
        if (timestamp_out !== 100 || freq_out !== 48'h1000 || phase_out !== 14'h155 ||
            time_offset_out !== 100 || param_update !== 1'b1) begin
            fails++;
            $display("FAIL timed_apply: ts=%0d freq=%0h ph=%0h off=%0d upd=%b, required 100/1000/155/100/1",
                     timestamp_out, freq_out, phase_out, time_offset_out, param_update);
        end
        tick();
        checks++;
        if (param_update !== 1'b0) begin
            fails++;
            $display("FAIL timed_pulse_width: upd=%b one cycle after apply, required 0", param_update);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) push_cmd(200 + i, 48'h2000 + i, 14'(i), 1'b0);
        checks++;
        if ({fifo_full, cmd_ready, fifo_empty} !== 3'b100) begin
            fails++;
            $display("FAIL full_flags: full/ready/empty=%b%b%b required 100", fifo_full, cmd_ready, fifo_empty);
        end
        push_cmd(204, 48'hDEAD, 14'h3FF, 1'b1);
        wait_ts(199);
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (param_update !== 1'b1 || freq_out !== 48'h2000 + i || timestamp_out !== 200 + i ||
                time_offset_out !== 100) begin
                fails++;
                $display("FAIL full_apply_%0d: upd=%b freq=%0h ts=%0d off=%0d, required 1/%0h/%0d/100",
                         i, param_update, freq_out, timestamp_out, time_offset_out, 48'h2000 + i, 200 + i);
            end
        end
        tick();
        checks++;
        if (param_update !== 1'b0 || fifo_empty !== 1'b1 || freq_out !== 48'h2003) begin
            fails++;
            $display("FAIL full_fifth_ignored: upd=%b empty=%b freq=%0h, required 0/1/2003",
                     param_update, fifo_empty, freq_out);
        end
    endtask

    task automatic test_late();
        push_cmd(50, 48'h3333, 14'h77, 1'b1);
        checks++;
        if (param_update !== 1'b0 || late_error !== 1'b0) begin
            fails++;
            $display("FAIL late_visible: upd=%b late=%b when head appears, required 0/0", param_update, late_error);
        end
        tick();
        checks++;
`ifdef DDS_SCHED_LATE_DROP_EN
        if (late_error !== 1'b1 || param_update !== 1'b0 || freq_out !== 48'h2003 || time_offset_out !== 100) begin
            fails++;
            $display("FAIL late_drop: late=%b upd=%b freq=%0h off=%0d, required 1/0/2003/100",
                     late_error, param_update, freq_out, time_offset_out);
        end
`else
        if (late_error !== 1'b1 || param_update !== 1'b1 || freq_out !== 48'h3333 ||
            phase_out !== 14'h77 || time_offset_out !== 50) begin
            fails++;
            $display("FAIL late_apply: late=%b upd=%b freq=%0h ph=%0h off=%0d, required 1/1/3333/77/50",
                     late_error, param_update, freq_out, phase_out, time_offset_out);
        end
`endif
        tick();
        checks++;
        if (fifo_empty !== 1'b1 || late_error !== 1'b1) begin
            fails++;
            $display("FAIL late_sticky: empty=%b late=%b, required 1/1", fifo_empty, late_error);
        end
    endtask

    task automatic test_sync0();
        push_cmd(220, 48'h4444, 14'h11, 1'b1);
        push_cmd(225, 48'h5555, 14'h22, 1'b0);
        wait_ts(220);
        checks++;
        if (time_offset_out !== 220 || freq_out !== 48'h4444 || param_update !== 1'b1) begin
            fails++;
            $display("FAIL sync1_apply: off=%0d freq=%0h upd=%b, required 220/4444/1",
                     time_offset_out, freq_out, param_update);
        end
        wait_ts(225);
        checks++;
        if (time_offset_out !== 220 || freq_out !== 48'h5555 || phase_out !== 14'h22 || param_update !== 1'b1) begin
            fails++;
            $display("FAIL sync0_hold: off=%0d freq=%0h ph=%0h upd=%b, required 220/5555/22/1",
                     time_offset_out, freq_out, phase_out, param_update);
        end
    endtask

    task automatic test_flush();
        int seen = 0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (late_error !== 1'b0 || timestamp_out !== 0) begin
            fails++;
            $display("FAIL reset_clears_late: late=%b ts=%0d, required 0/0", late_error, timestamp_out);
        end
        for (int i = 0; i < 3; i++) push_cmd(40 + i, 48'h6000 + i, 14'h5, 1'b1);
        wait_ts(20);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (fifo_empty !== 1'b1 || timestamp_out !== 20 || param_update !== 1'b0 ||
            freq_out !== '0 || time_offset_out !== '0) begin
            fails++;
            $display("FAIL flush: empty=%b ts=%0d upd=%b freq=%0h off=%0d, required 1/20/0/0/0",
                     fifo_empty, timestamp_out, param_update, freq_out, time_offset_out);
        end
        while (m_ts != 50) begin
            tick();
            if (param_update !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            fails++;
            $display("FAIL flush_no_apply: %0d updates after flush, required 0", seen);
        end
    endtask

    task automatic test_random();
        logic [162:0] got, exp;
        int shown = 0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_time  = m_ts + W'($urandom_range(0, 24)) - W'(6);
            cmd_freq  = {16'($urandom), 32'($urandom)};
            cmd_phase = 14'($urandom);
            cmd_sync  = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 39) == 0);
            reset     = ($urandom_range(0, 499) == 0);
            tick();
            got = {timestamp_out, time_offset_out, freq_out, phase_out, param_update,
                   fifo_empty, fifo_full, cmd_ready, late_error};
            exp = {m_ts, m_off, m_freq, m_phase, m_upd,
                   mq.size() == 0, mq.size() == D, mq.size() != D, m_late};
            checks++;
            if (got !== exp) begin
                fails++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL random_cycle_%0d: dut=%h model=%h", n, got, exp);
                end
            end
        end
        cmd_valid = 1'b0; flush = 1'b0; reset = 1'b0;
    endtask

    task automatic test_wrap();
        int unsigned wts;
        int early = 0;
        w_reset = 1'b1;
        tick();
        w_reset = 1'b0;
        wts = 0;
        while (wts != 1021) begin tick(); wts++; end
        w_valid = 1'b1; w_time = 1; w_freq = 10'h2A5; w_phase = 14'h3; w_sync = 1'b1;
        tick(); wts = (wts + 1) % 1024;
        w_valid = 1'b0;
        while (wts != 1) begin
            if (w_upd !== 1'b0) early++;
            tick(); wts = (wts + 1) % 1024;
        end
        checks++;
        if (w_ts !== 1 || w_upd !== 1'b1 || w_fout !== 10'h2A5 || w_off !== 1 || w_late !== 1'b0 || early != 0) begin
            fails++;
            $display("FAIL wrap_apply: ts=%0d upd=%b freq=%0h off=%0d late=%b early=%0d, required 1/1/2a5/1/0/0",
                     w_ts, w_upd, w_fout, w_off, w_late, early);
        end
        // Furthest-future command: one cycle short of half the counter range.
        w_valid = 1'b1; w_time = WW'(wts + 513); w_sync = 1'b0;
        tick(); wts++;
        w_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin tick(); wts++; end
        checks++;
        if (w_late !== 1'b0 || w_upd !== 1'b0 || w_empty !== 1'b0) begin
            fails++;
            $display("FAIL wrap_horizon_future: late=%b upd=%b empty=%b, required 0/0/0", w_late, w_upd, w_empty);
        end
        w_flush = 1'b1;
        tick();
        w_flush = 1'b0;
        // One beyond the horizon wraps to a negative distance: late.
        w_valid = 1'b1; w_time = WW'(wts + 514);
        tick();
        w_valid = 1'b0;
        tick();
        checks++;
        if (w_late !== 1'b1 || w_empty !== 1'b1) begin
            fails++;
            $display("FAIL wrap_horizon_late: late=%b empty=%b, required 1/1", w_late, w_empty);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        test_reset();
        test_timed_apply();
        test_full();
        test_late();
        test_sync0();
        test_flush();
        test_random();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
